dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum consecutive locked grants to port B while port A is requesting.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 a_req, a_we  in  1 each  port A (pipeline MEM stage) request; we=1 write, we=0 read.
REQ-005 a_addr, a_wdata  in  32 each  port A word address, signed write data.
REQ-006 a_gnt  out  1  port A granted this cycle; transfer occurs at the edge where a_req&a_gnt.
REQ-007 a_rvalid  out  1, a_rdata  out  32  port A read data valid / value.
REQ-008 b_req, b_we, b_lock  in  1 each  port B (loader/debug) request, write select, burst lock.
REQ-009 b_addr, b_wdata  in  32 each; b_gnt, b_rvalid  out  1; b_rdata  out  32; same meaning as port A.
REQ-010 mem_write_enable, mem_read_enable  out  1 each; mem_address, mem_write_data  out  32 each  command to single-port data memory.
REQ-011 mem_read_data  in  32  memory read data, valid one cycle after the read command edge.

Function
REQ-012 At most one of a_gnt/b_gnt SHALL be high in any cycle; a grant is issued only to a requesting port.
REQ-013 a_gnt, b_gnt and all mem_* command outputs SHALL be combinational from current requests and registered arbiter state.
REQ-014 Granted port's addr/wdata SHALL drive mem_address/mem_write_data; mem_write_enable=gnt&we, mem_read_enable=gnt&~we; with no grant both enables SHALL be 0 and mem_address/mem_write_data 0.
REQ-015 States: ARB and BURST_B (2-bit encoding allowed), plus registers last_owner, burst_cnt (3+ bits, sized to MAX_BURST), rd_pending, rd_owner.
REQ-016 ARB, single requester: that port SHALL be granted.
REQ-017 ARB, both requesting: the port not equal to last_owner SHALL be granted (round-robin); last_owner updates to the granted port on each transfer.
REQ-018 ARB -> BURST_B when B transfers with b_lock=1; burst_cnt loads 1.
REQ-019 BURST_B: B SHALL hold grant while b_req&b_lock, even if A requests, until burst_cnt reaches MAX_BURST with a_req=1; then that cycle A SHALL be granted and state returns to ARB.
REQ-020 BURST_B: burst_cnt increments per B transfer, saturating at MAX_BURST; counter is not checked when a_req=0 (B may continue indefinitely).
REQ-021 BURST_B -> ARB when b_req=0 or b_lock=0; that cycle arbitrates as ARB.
REQ-022 On a read transfer, rd_pending<=1 and rd_owner<=granted port; otherwise rd_pending<=0.
REQ-023 x_rvalid SHALL equal rd_pending & (rd_owner==x); a_rdata and b_rdata SHALL both carry mem_read_data (qualified by rvalid).
REQ-024 Back-to-back reads, including alternating owners, SHALL be issued every cycle with each return steered to its own issuer.
REQ-025 Write followed by read to the same address on consecutive cycles SHALL return the written data (memory ordering preserved, no reordering).
REQ-026 Latency: grant same cycle as request (0 wait if uncontended); read data one cycle after transfer edge.

Reset
REQ-027 While reset=1: a_gnt=b_gnt=0, mem enables=0, mem_address=mem_write_data=0, a_rvalid=b_rvalid=0.
REQ-028 At reset edge: state<=ARB, last_owner<=B (so A wins first contention), burst_cnt<=0, rd_pending<=0, rd_owner<=A.
REQ-029 Reset asserted mid-burst or with a read pending SHALL discard the burst and suppress the pending rvalid on the following cycle.

Verification
REQ-030 Memory preloaded addr1=3123, addr9=5783; A reads addr 1 alone -> a_gnt same cycle, mem_read_enable=1, next cycle a_rvalid=1, a_rdata=3123, b_rvalid=0.
REQ-031 A and B both read (A addr 1, B addr 9) for 2 cycles after reset -> grants A,B; returns a_rdata=3123 then b_rdata=5783.
REQ-032 A writes 17 to addr 78, next cycle B reads addr 78 -> b_rvalid with b_rdata=17.
REQ-033 B locked burst of 6 writes (addr 100..105) with a_req held from B's first transfer, MAX_BURST=4 -> B granted 4 cycles, A granted 5th cycle, B resumes next.
REQ-034 Both idle -> no enables asserted; simultaneous requests with last_owner=A -> B granted.
REQ-035 Reset asserted cycle after A read of addr 9 -> a_rvalid stays 0, all grants 0 during reset, A wins first contention after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: round-robin between
// the pipeline port (A) and the loader/debug port (B), with bounded B bursts.
module dmem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic        b_lock,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int CW = ($clog2(MAX_BURST + 1) > 3) ? $clog2(MAX_BURST + 1) : 3;

  typedef enum logic [1:0] {ARB = 2'b00, BURST_B = 2'b01} state_t;
  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

  state_t          state, state_nxt;
  owner_t          last_owner, rd_owner;
  logic [CW-1:0]   burst_cnt, burst_cnt_nxt;
  logic            rd_pending;
  logic            gnt_a, gnt_b;

  always_comb begin
    gnt_a         = 1'b0;
    gnt_b         = 1'b0;
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    if (!reset) begin
      if (state == BURST_B && b_req && b_lock) begin
        // The burst cap only matters when A is actually waiting.
        if (a_req && burst_cnt >= CW'(MAX_BURST)) begin
          gnt_a         = 1'b1;
          state_nxt     = ARB;
          burst_cnt_nxt = '0;
        end else begin
          gnt_b = 1'b1;
          if (burst_cnt < CW'(MAX_BURST))
            burst_cnt_nxt = burst_cnt + 1'b1;
        end
      end else begin
        state_nxt     = ARB;
        burst_cnt_nxt = '0;
        if (a_req && b_req) begin
          gnt_a = (last_owner == OWN_B);
          gnt_b = (last_owner == OWN_A);
        end else begin
          gnt_a = a_req;
          gnt_b = b_req;
        end
        if (gnt_b && b_lock) begin
          state_nxt     = BURST_B;
          burst_cnt_nxt = CW'(1);
        end
      end
    end
  end

  assign a_gnt            = gnt_a;
  assign b_gnt            = gnt_b;
  assign mem_write_enable = (gnt_a & a_we) | (gnt_b & b_we);
  assign mem_read_enable  = (gnt_a & ~a_we) | (gnt_b & ~b_we);
  assign mem_address      = gnt_a ? a_addr  : (gnt_b ? b_addr  : '0);
  assign mem_write_data   = gnt_a ? a_wdata : (gnt_b ? b_wdata : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      last_owner <= OWN_B;
      burst_cnt  <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= OWN_A;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_cnt_nxt;
      rd_pending <= mem_read_enable;
      if (gnt_a || gnt_b)
        last_owner <= gnt_a ? OWN_A : OWN_B;
      if (mem_read_enable)
        rd_owner <= gnt_a ? OWN_A : OWN_B;
    end
  end

  assign a_rvalid = ~reset & rd_pending & (rd_owner == OWN_A);
  assign b_rvalid = ~reset & rd_pending & (rd_owner == OWN_B);
  assign a_rdata  = mem_read_data;
  assign b_rdata  = mem_read_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, reference memory and a read
// scoreboard checked against grants, memory commands and read returns.
module tb_dmem_arbiter;

  logic        clk, reset;
  logic        a_req, a_we, a_gnt, a_rvalid;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_we, b_lock, b_gnt, b_rvalid;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        mem_write_enable, mem_read_enable;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        owner_b;
    logic [31:0] data;
  } rd_t;
  rd_t sb[$];

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  dmem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address[7:0]] <= mem_write_data;
    if (mem_read_enable)  mem_read_data <= mem[mem_address[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // eg: expected grant 0=none, 1=A, 2=B
  task automatic drive_cycle(input logic ar, input logic awe, input logic [31:0] aad,
                             input logic [31:0] awd, input logic br, input logic bwe,
                             input logic bl, input logic [31:0] bad, input logic [31:0] bwd,
                             input int eg, input string tag);
    rd_t e;
    logic [31:0] x_addr, x_wd;
    logic x_we;
    a_req = ar; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = br; b_we = bwe; b_lock = bl; b_addr = bad; b_wdata = bwd;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".a_rvalid"}, 32'(a_rvalid), 32'(!e.owner_b));
      check({tag, ".b_rvalid"}, 32'(b_rvalid), 32'(e.owner_b));
      check({tag, ".rdata"}, e.owner_b ? b_rdata : a_rdata, e.data);
    end else begin
      check({tag, ".a_rvalid"}, 32'(a_rvalid), 32'd0);
      check({tag, ".b_rvalid"}, 32'(b_rvalid), 32'd0);
    end
    x_addr = (eg == 1) ? aad : (eg == 2) ? bad : 32'd0;
    x_wd   = (eg == 1) ? awd : (eg == 2) ? bwd : 32'd0;
    x_we   = (eg == 1) ? awe : bwe;
    check({tag, ".gnt"}, {30'd0, b_gnt, a_gnt}, 32'(eg));
    check({tag, ".mem_addr"}, mem_address, x_addr);
    check({tag, ".mem_wdata"}, mem_write_data, x_wd);
    check({tag, ".mem_en"}, {30'd0, mem_write_enable, mem_read_enable},
          (eg == 0) ? 32'd0 : (x_we ? 32'd2 : 32'd1));
    if (eg != 0) begin
      if (x_we) ref_mem[x_addr[7:0]] = x_wd;
      else      sb.push_back('{owner_b: (eg == 2), data: ref_mem[x_addr[7:0]]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem[1] = 32'd3123; ref_mem[1] = 32'd3123;
    mem[9] = 32'd5783; ref_mem[9] = 32'd5783;
    mem_read_data = 32'd0;
    reset = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0;

    drive_cycle(1, 0, 1, 0, 1, 1, 1, 9, 44, 0, "rst0");
    drive_cycle(1, 1, 5, 6, 1, 0, 0, 9, 0, 0, "rst1");
    reset = 1'b0;

    // A reads alone
    drive_cycle(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, "a_rd1");
    idle("a_rd1_ret");

    // both read right after reset: A first, then B
    reset = 1'b1; sb.delete();
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst2");
    reset = 1'b0;
    drive_cycle(1, 0, 1, 0, 1, 0, 0, 9, 0, 1, "rr_a");
    drive_cycle(1, 0, 1, 0, 1, 0, 0, 9, 0, 2, "rr_b");
    idle("rr_ret");

    // A writes, B reads same address next cycle
    drive_cycle(1, 1, 78, 17, 0, 0, 0, 0, 0, 1, "a_wr78");
    drive_cycle(0, 0, 0, 0, 1, 0, 0, 78, 0, 2, "b_rd78");
    idle("b_rd78_ret");

    // last_owner=A, contention -> B
    drive_cycle(1, 0, 9, 0, 0, 0, 0, 0, 0, 1, "a_rd9");
    drive_cycle(1, 0, 1, 0, 1, 0, 0, 9, 0, 2, "cont_b");
    idle("cont_ret");

    // locked B burst capped at 4 while A waits
    drive_cycle(1, 1, 200, 55, 0, 0, 0, 0, 0, 1, "pre_a");
    for (int i = 0; i < 4; i++)
      drive_cycle(1, 0, 1, 0, 1, 1, 1, 100 + i, 1000 + i, 2, $sformatf("burst%0d", i));
    drive_cycle(1, 0, 1, 0, 1, 1, 1, 104, 1004, 1, "burst_a");
    drive_cycle(1, 0, 9, 0, 1, 1, 1, 104, 1004, 2, "burst_resume");
    drive_cycle(1, 0, 9, 0, 1, 1, 1, 105, 1005, 2, "burst_last");
    drive_cycle(1, 0, 9, 0, 0, 0, 0, 0, 0, 1, "burst_end");
    drive_cycle(0, 0, 0, 0, 1, 0, 0, 105, 0, 2, "burst_rd");
    idle("burst_rd_ret");

    // unbounded locked burst with A idle, then unlock with contention
    for (int i = 0; i < 6; i++)
      drive_cycle(0, 0, 0, 0, 1, 1, 1, 120 + i, 7 * i, 2, $sformatf("long%0d", i));
    drive_cycle(1, 0, 121, 0, 1, 0, 0, 125, 0, 1, "unlock_a");
    drive_cycle(0, 0, 0, 0, 1, 0, 0, 125, 0, 2, "unlock_b");
    idle("unlock_ret");

    // write then read same address on A, signed data
    drive_cycle(1, 1, 50, -7, 0, 0, 0, 0, 0, 1, "raw_wr");
    drive_cycle(1, 0, 50, 0, 0, 0, 0, 0, 0, 1, "raw_rd");
    idle("raw_ret");

    // reset with a read pending: return suppressed, A wins afterwards
    drive_cycle(1, 0, 9, 0, 0, 0, 0, 0, 0, 1, "pend_rd");
    reset = 1'b1; sb.delete();
    drive_cycle(1, 0, 9, 0, 1, 0, 0, 1, 0, 0, "pend_rst");
    reset = 1'b0;
    drive_cycle(1, 0, 9, 0, 1, 0, 0, 1, 0, 1, "post_rst_a");
    idle("post_rst_ret");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
